// File: rtl/stage_sequencer_pkg.sv
// rtl/stage_sequencer_pkg.sv - shared state encodings and opcode constants for sequencing and decode control
package stage_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6,
    ST_FAULT   = 3'd7
  } seq_state_e;

  localparam logic [6:0] OP_LOAD         = 7'b0000011;
  localparam logic [6:0] OP_STORE        = 7'b0100011;
  localparam logic [6:0] OP_BRANCH       = 7'b1100011;
  localparam logic [6:0] OP_FENCE        = 7'b0001111;
  localparam logic [6:0] OP_ECALL_EBREAK = 7'b1110011;

  function automatic logic op_is_mem(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // Instructions with no destination register must not strobe the register file.
  function automatic logic op_writes_rf(input logic [6:0] op);
    return !((op == OP_BRANCH) || (op == OP_STORE) ||
             (op == OP_FENCE)  || (op == OP_ECALL_EBREAK));
  endfunction

endpackage

// File: rtl/seq_timeout_ctr.sv
// rtl/seq_timeout_ctr.sv - memory-ack wait counter, expired once TIMEOUT un-acked cycles are counted
module seq_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  assign expired = (count == 8'(TIMEOUT));

  // Holds at TIMEOUT so a late ack in the expiry cycle still sees a stable value.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= 8'd0;
    end else if (enable && !expired) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - multi-cycle fetch/decode/execute/mem/wb sequencer with halt and ack-timeout fault
// Optional SEQ_PERF_CNT_EN adds a 32-bit retired-instruction counter output.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] opcode,
  input  logic       halt_flag,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       ir_we,
  output logic       control_enable,
  output logic       pc_we,
  output logic       rf_we_strobe,
  output logic [2:0] state,
  output logic       halted,
  output logic       fault
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] retired
`endif
);

  seq_state_e state_q, state_d;
  logic       timer_expired;
  logic       timer_clear;
  logic       timer_enable;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack)           state_d = ST_DECODE;
        else if (timer_expired) state_d = ST_FAULT;
      end
      ST_DECODE:  state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (halt_flag)              state_d = ST_HALT;
        else if (op_is_mem(opcode)) state_d = ST_MEM;
        else                        state_d = ST_WB;
      end
      ST_MEM: begin
        if (dmem_ack)           state_d = ST_WB;
        else if (timer_expired) state_d = ST_FAULT;
      end
      ST_WB:      state_d = ST_FETCH;
      ST_HALT:    state_d = ST_HALT;
      ST_FAULT:   state_d = ST_FAULT;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Every state change clears the counter, so each FETCH/MEM visit starts at zero.
  assign timer_clear  = (state_d != state_q);
  assign timer_enable = ((state_q == ST_FETCH) && !imem_ack) ||
                        ((state_q == ST_MEM)   && !dmem_ack);

  seq_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // Outputs are masked while rst is high so nothing leaks during the reset cycle.
  always_comb begin
    imem_req       = 1'b0;
    dmem_req       = 1'b0;
    ir_we          = 1'b0;
    control_enable = 1'b0;
    pc_we          = 1'b0;
    rf_we_strobe   = 1'b0;
    halted         = 1'b0;
    fault          = 1'b0;
    state          = 3'd0;
    if (!rst) begin
      state = state_q;
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
        end
        ST_DECODE, ST_EXECUTE: control_enable = 1'b1;
        ST_MEM: begin
          control_enable = 1'b1;
          dmem_req       = 1'b1;
        end
        ST_WB: begin
          control_enable = 1'b1;
          pc_we          = 1'b1;
          rf_we_strobe   = op_writes_rf(opcode);
        end
        ST_HALT:  halted = 1'b1;
        ST_FAULT: fault  = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retired <= 32'd0;
    end else if (pc_we) begin
      retired <= retired + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - directed self-checking bench for stage_sequencer (TIMEOUT=4)
module tb_stage_sequencer;

  localparam logic [6:0] ADDI   = 7'b0010011;
  localparam logic [6:0] ADD    = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] FENCE  = 7'b0001111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       halt_flag = 1'b0;
  logic       imem_ack = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       imem_req, dmem_req, ir_we, control_enable, pc_we, rf_we_strobe;
  logic [2:0] state;
  logic       halted, fault;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired;
`endif

  int checks = 0;
  int failures = 0;

  stage_sequencer #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .opcode         (opcode),
    .halt_flag      (halt_flag),
    .imem_ack       (imem_ack),
    .dmem_ack       (dmem_ack),
    .imem_req       (imem_req),
    .dmem_req       (dmem_req),
    .ir_we          (ir_we),
    .control_enable (control_enable),
    .pc_we          (pc_we),
    .rf_we_strobe   (rf_we_strobe),
    .state          (state),
    .halted         (halted),
    .fault          (fault)
`ifdef SEQ_PERF_CNT_EN
    ,
    .retired        (retired)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] outs();
    return {imem_req, dmem_req, ir_we, control_enable, pc_we, rf_we_strobe, halted, fault};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_fetch();
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; halt_flag = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered with state==FETCH; dack_delay < 0 means a non-memory instruction.
  task automatic run_instr(input logic [6:0] op, input logic hflag, input int dack_delay,
                           input logic exp_rf, input string nm);
    int dreq_cycles;
    int lat;
    int exp_lat;
    dreq_cycles = 0;
    lat = 0;
    exp_lat = (dack_delay < 0) ? 4 : 5 + dack_delay;
    opcode = op; halt_flag = hflag; imem_ack = 1'b1;
    #1;
    checks++;
    if (state !== 3'd1 || ir_we !== 1'b1 || imem_req !== 1'b1)
      begin failures++; $display("FAIL %s_fetch: state=%0d ir_we=%b imem_req=%b, want 1 1 1", nm, state, ir_we, imem_req); end
    tick(); lat++;
    imem_ack = 1'b0;
    #1;
    checks++;
    if (state !== 3'd2 || control_enable !== 1'b1 || ir_we !== 1'b0)
      begin failures++; $display("FAIL %s_decode: state=%0d ce=%b ir_we=%b, want 2 1 0", nm, state, control_enable, ir_we); end
    tick(); lat++;
    checks++;
    if (state !== 3'd3 || control_enable !== 1'b1)
      begin failures++; $display("FAIL %s_execute: state=%0d ce=%b, want 3 1", nm, state, control_enable); end
    if (hflag) begin
      tick();
      checks++;
      if (state !== 3'd6 || halted !== 1'b1 || pc_we !== 1'b0 || control_enable !== 1'b0)
        begin failures++; $display("FAIL %s_halt: state=%0d halted=%b pc_we=%b ce=%b, want 6 1 0 0", nm, state, halted, pc_we, control_enable); end
      halt_flag = 1'b0;
      return;
    end
    tick(); lat++;
    for (int c = 0; c <= dack_delay; c++) begin
      dmem_ack = (c == dack_delay);
      #1;
      if (dmem_req === 1'b1) dreq_cycles++;
      checks++;
      if (state !== 3'd4)
        begin failures++; $display("FAIL %s_mem: cycle %0d state=%0d, want 4", nm, c, state); end
      tick(); lat++;
    end
    dmem_ack = 1'b0;
    #1;
    if (dack_delay >= 0) begin
      checks++;
      if (dreq_cycles != dack_delay + 1)
        begin failures++; $display("FAIL %s_dreq_cycles: got %0d want %0d", nm, dreq_cycles, dack_delay + 1); end
    end
    checks++;
    if (state !== 3'd5 || pc_we !== 1'b1 || rf_we_strobe !== exp_rf || dmem_req !== 1'b0)
      begin failures++; $display("FAIL %s_wb: state=%0d pc_we=%b rf_we=%b dmem_req=%b, want 5 1 %b 0", nm, state, pc_we, rf_we_strobe, dmem_req, exp_rf); end
    tick(); lat++;
    checks++;
    if (state !== 3'd1 || pc_we !== 1'b0 || rf_we_strobe !== 1'b0 || lat != exp_lat)
      begin failures++; $display("FAIL %s_refetch: state=%0d pc_we=%b rf_we=%b latency=%0d, want 1 0 0 %0d", nm, state, pc_we, rf_we_strobe, lat, exp_lat); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    tick(); tick();
    checks++;
    if (state !== 3'd0 || outs() !== 8'h00)
      begin failures++; $display("FAIL reset_during: state=%0d outs=%h, want 0 00", state, outs()); end
    rst = 1'b0; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0 || outs() !== 8'h00)
      begin failures++; $display("FAIL reset_after: state=%0d outs=%h, want 0 00", state, outs()); end
  endtask

  task automatic test_ignored_acks();
    imem_ack = 1'b1; dmem_ack = 1'b1;
    tick(); tick();
    checks++;
    if (state !== 3'd0 || outs() !== 8'h00)
      begin failures++; $display("FAIL idle_acks: state=%0d outs=%h, want 0 00", state, outs()); end
    imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic test_addi();
    go_fetch();
    run_instr(ADDI, 1'b0, -1, 1'b1, "addi");
  endtask

  task automatic test_load_store();
    go_fetch();
    run_instr(LOAD, 1'b0, 3, 1'b1, "lw");
    run_instr(STORE, 1'b0, 3, 1'b0, "sw");
    run_instr(LOAD, 1'b0, 0, 1'b1, "lw_fast");
  endtask

  task automatic test_back_to_back();
    go_fetch();
    run_instr(BRANCH, 1'b0, -1, 1'b0, "branch");
    run_instr(FENCE, 1'b0, -1, 1'b0, "fence");
    run_instr(ADD, 1'b0, -1, 1'b1, "add");
    run_instr(SYSTEM, 1'b0, -1, 1'b0, "system_nohalt");
  endtask

  task automatic test_timeout();
    go_fetch();
    for (int k = 0; k <= 4; k++) begin
      checks++;
      if (state !== 3'd1 || fault !== 1'b0)
        begin failures++; $display("FAIL timeout_wait: cycle %0d state=%0d fault=%b, want 1 0", k, state, fault); end
      tick();
    end
    checks++;
    if (state !== 3'd7 || fault !== 1'b1 || imem_req !== 1'b0)
      begin failures++; $display("FAIL timeout_fault: state=%0d fault=%b imem_req=%b, want 7 1 0", state, fault, imem_req); end
    start = 1'b1; imem_ack = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (state !== 3'd7 || outs() !== 8'h01)
      begin failures++; $display("FAIL fault_sticky: state=%0d outs=%h, want 7 01", state, outs()); end
    start = 1'b0; imem_ack = 1'b0;
  endtask

  task automatic test_timeout_ack_edge();
    go_fetch();
    for (int k = 0; k < 4; k++) tick();
    imem_ack = 1'b1;
    #1;
    checks++;
    if (state !== 3'd1 || ir_we !== 1'b1)
      begin failures++; $display("FAIL ack_at_limit_fetch: state=%0d ir_we=%b, want 1 1", state, ir_we); end
    tick();
    imem_ack = 1'b0;
    #1;
    checks++;
    if (state !== 3'd2 || fault !== 1'b0)
      begin failures++; $display("FAIL ack_at_limit_decode: state=%0d fault=%b, want 2 0", state, fault); end
  endtask

  task automatic test_halt();
    go_fetch();
    run_instr(SYSTEM, 1'b1, -1, 1'b0, "ecall");
    start = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (state !== 3'd6 || outs() !== 8'h02)
        begin failures++; $display("FAIL halt_sticky: cycle %0d state=%0d outs=%h, want 6 02", k, state, outs()); end
    end
    start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_mem();
    go_fetch();
    opcode = LOAD; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick(); tick();
    checks++;
    if (state !== 3'd4 || dmem_req !== 1'b1)
      begin failures++; $display("FAIL mid_mem_enter: state=%0d dmem_req=%b, want 4 1", state, dmem_req); end
    tick();
    rst = 1'b1; dmem_ack = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || outs() !== 8'h00)
      begin failures++; $display("FAIL mid_mem_rst_during: state=%0d outs=%h, want 0 00", state, outs()); end
    tick();
    rst = 1'b0; dmem_ack = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || outs() !== 8'h00)
      begin failures++; $display("FAIL mid_mem_rst_after: state=%0d outs=%h, want 0 00", state, outs()); end
    tick();
    checks++;
    if (state !== 3'd0 || pc_we !== 1'b0)
      begin failures++; $display("FAIL mid_mem_no_wb: state=%0d pc_we=%b, want 0 0", state, pc_we); end
  endtask

`ifdef SEQ_PERF_CNT_EN
  task automatic test_perf();
    go_fetch();
    checks++;
    if (retired !== 32'd0)
      begin failures++; $display("FAIL retired_reset: got %0d want 0", retired); end
    for (int i = 0; i < 10; i++) run_instr(ADDI, 1'b0, -1, 1'b1, "perf_addi");
    checks++;
    if (retired !== 32'd10)
      begin failures++; $display("FAIL retired_count: got %0d want 10", retired); end
    force dut.retired = 32'hFFFF_FFFE;
    #1;
    release dut.retired;
    run_instr(ADDI, 1'b0, -1, 1'b1, "wrap1");
    run_instr(ADDI, 1'b0, -1, 1'b1, "wrap2");
    checks++;
    if (retired !== 32'd0)
      begin failures++; $display("FAIL retired_wrap: got %h want 00000000", retired); end
  endtask
`endif

  initial begin
    test_reset();
    test_ignored_acks();
    test_addi();
    test_load_store();
    test_back_to_back();
    test_timeout();
    test_timeout_ack_edge();
    test_halt();
    test_reset_mid_mem();
`ifdef SEQ_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
